// File: rtl/jtkiwi_pal_dma_if.sv
// ROM fetch, CPU palette write and palette RAM write-port signals of the palette upload engine.
// master = engine side, slave = the ROM/CPU/RAM environment around it.
interface jtkiwi_pal_dma_if;
  logic        rom_cs;
  logic [8:0]  rom_addr;
  logic        rom_ok;
  logic [15:0] rom_data;
  logic [9:0]  cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic [9:0]  pal_addr;
  logic [7:0]  pal_dout;
  logic        pal_we;

  modport master (
    output rom_cs, rom_addr,
    input  rom_ok, rom_data,
    input  cpu_addr, cpu_dout, cpu_we,
    output pal_addr, pal_dout, pal_we
  );

  modport slave (
    input  rom_cs, rom_addr,
    output rom_ok, rom_data,
    output cpu_addr, cpu_dout, cpu_we,
    input  pal_addr, pal_dout, pal_we
  );
endinterface

// File: rtl/jtkiwi_pal_dma.sv
// Palette upload: copies COLORS 16-bit ROM words into palette RAM as low/high byte writes, 4 cycles/colour best case.
// Backpressure: waits on rom_ok; engine writes stall while the CPU writes or (VBONLY) outside vertical blank.
module jtkiwi_pal_dma #(
  parameter int COLORS = 512,
  parameter bit VBONLY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             LVBL,
  input  logic             start,
  output logic             busy,
  output logic             done,
  jtkiwi_pal_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, WRLO, WRHI} state_t;

  localparam logic [8:0] LAST = 9'(COLORS - 1);

  state_t      state_q, state_d;
  logic [8:0]  idx_q, idx_d;
  logic [15:0] latch_q, latch_d;
  logic        fetch_arm_q, fetch_arm_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        grant;
  logic        eng_req;
  logic        eng_we;
  logic [9:0]  eng_addr;
  logic [7:0]  eng_dat;

  // The CPU always owns the port; the engine may also be fenced to vertical blank.
  assign grant = !bus.cpu_we && (!VBONLY || !LVBL);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    latch_d     = latch_q;
    fetch_arm_d = fetch_arm_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = 9'd0;
          fetch_arm_d = 1'b0;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // First cycle only presents the address; a leftover rom_ok belongs to the old address.
        if (!fetch_arm_q) begin
          fetch_arm_d = 1'b1;
        end else if (bus.rom_ok) begin
          latch_d = bus.rom_data;
          state_d = WRLO;
        end
      end
      WRLO: begin
        if (grant) state_d = WRHI;
      end
      WRHI: begin
        if (grant) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d       = idx_q + 9'd1;
            fetch_arm_d = 1'b0;
            state_d     = FETCH;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 9'd0;
      latch_q     <= 16'd0;
      fetch_arm_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      latch_q     <= latch_d;
      fetch_arm_q <= fetch_arm_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Engine writes are masked during reset so an aborted transfer leaves no partial byte.
  assign eng_req  = ((state_q == WRLO) || (state_q == WRHI)) && !rst;
  assign eng_we   = eng_req && grant;
  assign eng_addr = {state_q == WRHI, idx_q};
  assign eng_dat  = (state_q == WRHI) ? latch_q[15:8] : latch_q[7:0];

  always_comb begin
    bus.pal_addr = bus.cpu_addr;
    bus.pal_dout = bus.cpu_dout;
    bus.pal_we   = bus.cpu_we;
    if (!bus.cpu_we && eng_we) begin
      bus.pal_addr = eng_addr;
      bus.pal_dout = eng_dat;
      bus.pal_we   = 1'b1;
    end
  end

  assign bus.rom_cs   = (state_q == FETCH) && !rst;
  assign bus.rom_addr = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_jtkiwi_pal_dma.sv
module tb_jtkiwi_pal_dma;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lvbl, start, busy, done;
  logic start_b, busy_b, done_b;

  jtkiwi_pal_dma_if ifa ();
  jtkiwi_pal_dma_if ifb ();

  jtkiwi_pal_dma #(.COLORS(512), .VBONLY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .LVBL(lvbl), .start(start), .busy(busy), .done(done), .bus(ifa)
  );

  jtkiwi_pal_dma #(.COLORS(8), .VBONLY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .LVBL(1'b1), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int rom_mode = 0;
  int eng_k = 0;
  logic [8:0] a_prev_a = 9'd0;
  logic [8:0] a_prev_b = 9'd0;
  logic [7:0] ram_a [1024];
  bit         wr_a  [1024];
  logic [7:0] ram_b [1024];
  bit         wr_b  [1024];

  typedef struct {
    logic       rst;
    logic       cpu_we;
    logic [9:0] cpu_addr;
    logic [7:0] cpu_dout;
    logic       exp_we;
  } vec_t;

  function automatic logic [7:0] lo_of(input int n);
    return n[7:0];
  endfunction

  function automatic logic [7:0] hi_of(input int n);
    return n[7:0] ^ 8'hA5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      ram_a[i] = 8'h00; wr_a[i] = 1'b0;
      ram_b[i] = 8'h00; wr_b[i] = 1'b0;
    end
    eng_k = 0;
  endtask

  function automatic int image_bad_a();
    int bad = 0;
    for (int n = 0; n < 512; n++) begin
      if (!wr_a[n] || ram_a[n] !== lo_of(n)) bad++;
      if (!wr_a[512+n] || ram_a[512+n] !== hi_of(n)) bad++;
    end
    return bad;
  endfunction

  // ROM model: data reflects the address seen on the previous cycle, so the first
  // FETCH cycle of a new colour always carries stale data.
  initial begin
    ifa.rom_ok = 1'b0; ifa.rom_data = 16'h0;
    ifb.rom_ok = 1'b0; ifb.rom_data = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      ifa.rom_data = {hi_of(int'(a_prev_a)), lo_of(int'(a_prev_a))};
      ifb.rom_data = {hi_of(int'(a_prev_b)), lo_of(int'(a_prev_b))};
      ifb.rom_ok   = 1'b1;
      case (rom_mode)
        0:       ifa.rom_ok = 1'b1;
        1:       ifa.rom_ok = (cyc % 5 == 0);
        default: ifa.rom_ok = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Port monitor: records RAM, checks CPU pass-through and the in-order engine write stream.
  initial begin
    forever begin
      @(negedge clk);
      a_prev_a = ifa.rom_addr;
      a_prev_b = ifb.rom_addr;
      if (rst) eng_k = 0;
      if (ifa.pal_we) begin
        ram_a[ifa.pal_addr] = ifa.pal_dout;
        wr_a[ifa.pal_addr]  = 1'b1;
        if (ifa.cpu_we) begin
          chk("cpu_pass_addr", ifa.pal_addr, ifa.cpu_addr);
          chk("cpu_pass_data", ifa.pal_dout, ifa.cpu_dout);
        end else begin
          int n;
          n = eng_k / 2;
          chk("eng_in_blank", lvbl, 1'b0);
          chk("eng_write_in_range", eng_k < 1024, 1'b1);
          chk("eng_addr", ifa.pal_addr, (eng_k % 2 == 1) ? 512 + n : n);
          chk("eng_data", ifa.pal_dout, (eng_k % 2 == 1) ? hi_of(n) : lo_of(n));
          eng_k++;
        end
      end
      if (ifb.pal_we) begin
        ram_b[ifb.pal_addr] = ifb.pal_dout;
        wr_b[ifb.pal_addr]  = 1'b1;
      end
    end
  end

  // Mode: 0 plain + ignored starts, 1 CPU collision, 2 LVBL gating, 3 random, 4 reset abort, else plain.
  task automatic run_xfer(input int mode, input int maxc,
                          output int done_at, output int busy_n, output int dones);
    done_at = -1; busy_n = 0; dones = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= maxc; c++) begin
      case (mode)
        0: start = (c % 300 == 150);
        1: begin
          ifa.cpu_we   = (c == 15);
          ifa.cpu_addr = (c == 15) ? 10'h3FF : 10'h000;
          ifa.cpu_dout = 8'h5A;
        end
        2: lvbl = ((c / 200) % 2 == 0);
        3: begin
          ifa.cpu_we   = ($urandom_range(0, 9) == 0);
          ifa.cpu_addr = 10'($urandom);
          ifa.cpu_dout = 8'($urandom);
          lvbl         = ($urandom_range(0, 3) == 0);
          start        = (c < 2000) && ($urandom_range(0, 49) == 0);
        end
        4: rst = (c == 404 || c == 405);
        default: ;
      endcase
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (mode == 0 && c == 1) begin
        chk("c1_busy", busy, 1'b1);
        chk("c1_rom_cs", ifa.rom_cs, 1'b1);
        chk("c1_rom_addr", ifa.rom_addr, 9'd0);
      end
      if (mode == 1 && c == 15) begin
        chk("coll_cpu_we", ifa.pal_we, 1'b1);
        chk("coll_cpu_addr", ifa.pal_addr, 10'h3FF);
        chk("coll_cpu_data", ifa.pal_dout, 8'h5A);
      end
      if (mode == 1 && c == 16) begin
        chk("coll_eng_we", ifa.pal_we, 1'b1);
        chk("coll_eng_addr", ifa.pal_addr, 10'd3);
        chk("coll_eng_data", ifa.pal_dout, 8'd3);
      end
      if (mode == 4 && c == 404) chk("rst_no_wrhi", ifa.pal_we, 1'b0);
      if (mode == 4 && c == 405) begin
        chk("rst_busy", busy, 1'b0);
        chk("rst_rom_cs", ifa.rom_cs, 1'b0);
      end
      tick();
      if (mode == 4 && c == 410) break;
      if (done_at > 0 && c >= done_at + 5) break;
    end
    start = 1'b0; rst = 1'b0; lvbl = 1'b0; ifa.cpu_we = 1'b0;
  endtask

  vec_t vecs [6];
  int d_at, b_n, d_n;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 10'h155, 8'h33, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 10'h3FF, 8'h5A, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 10'h000, 8'hFF, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 10'h200, 8'h12, 1'b1};
    vecs[4] = '{1'b1, 1'b0, 10'h0AA, 8'h77, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 10'h3FF, 8'h00, 1'b0};

    rst = 1'b1; lvbl = 1'b0; start = 1'b0; start_b = 1'b0;
    ifa.cpu_we = 1'b0; ifa.cpu_addr = 10'h0; ifa.cpu_dout = 8'h0;
    ifb.cpu_we = 1'b0; ifb.cpu_addr = 10'h0; ifb.cpu_dout = 8'h0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("rst_state_busy", busy, 1'b0);
    chk("rst_state_done", done, 1'b0);
    chk("rst_state_rom_cs", ifa.rom_cs, 1'b0);
    chk("rst_state_rom_addr", ifa.rom_addr, 9'd0);
    chk("rst_state_pal_we", ifa.pal_we, 1'b0);
    chk("rst_state_busy_b", busy_b, 1'b0);
    tick();

    // Idle port mux, including pass-through while reset is held.
    for (int i = 0; i < 6; i++) begin
      rst = vecs[i].rst;
      ifa.cpu_we = vecs[i].cpu_we;
      ifa.cpu_addr = vecs[i].cpu_addr;
      ifa.cpu_dout = vecs[i].cpu_dout;
      @(negedge clk);
      chk($sformatf("vec%0d_we", i), ifa.pal_we, vecs[i].exp_we);
      chk($sformatf("vec%0d_addr", i), ifa.pal_addr, vecs[i].cpu_addr);
      chk($sformatf("vec%0d_data", i), ifa.pal_dout, vecs[i].cpu_dout);
      tick();
    end
    rst = 1'b0; ifa.cpu_we = 1'b0;
    tick();

    // Small unfenced instance: 8 colours, done at 4*8+1.
    clear_mem();
    d_at = -1; b_n = 0; d_n = 0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (busy_b) b_n++;
      if (done_b) begin
        d_n++;
        if (d_at < 0) d_at = c;
      end
      tick();
    end
    chk("b_done_cycle", d_at, 33);
    chk("b_busy_cycles", b_n, 32);
    chk("b_done_pulses", d_n, 1);
    begin
      int bad = 0;
      int cnt = 0;
      for (int n = 0; n < 8; n++) begin
        if (!wr_b[n] || ram_b[n] !== lo_of(n)) bad++;
        if (!wr_b[512+n] || ram_b[512+n] !== hi_of(n)) bad++;
      end
      for (int i = 0; i < 1024; i++) if (wr_b[i]) cnt++;
      chk("b_image_bad", bad, 0);
      chk("b_bytes_written", cnt, 16);
    end

    // Full copy, rom_ok held high (stale data on first FETCH), starts while busy.
    clear_mem(); rom_mode = 0; lvbl = 1'b0;
    run_xfer(0, 3000, d_at, b_n, d_n);
    chk("full_done_cycle", d_at, 2049);
    chk("full_busy_cycles", b_n, 2048);
    chk("full_done_pulses", d_n, 1);
    chk("full_image_bad", image_bad_a(), 0);
    chk("full_eng_writes", eng_k, 1024);

    // ROM latency: rom_ok every 5th cycle.
    clear_mem(); rom_mode = 1;
    run_xfer(5, 12000, d_at, b_n, d_n);
    chk("lat_done_pulses", d_n, 1);
    chk("lat_busy_vs_done", b_n, d_at - 1);
    chk("lat_image_bad", image_bad_a(), 0);
    chk("lat_eng_writes", eng_k, 1024);

    // CPU collision during colour 3 WRLO costs exactly one cycle.
    clear_mem(); rom_mode = 0;
    run_xfer(1, 3000, d_at, b_n, d_n);
    chk("coll_done_cycle", d_at, 2050);
    chk("coll_busy_cycles", b_n, 2049);
    chk("coll_done_pulses", d_n, 1);
    chk("coll_image_bad", image_bad_a(), 0);

    // Writes confined to vertical blank, start outside blank.
    clear_mem(); rom_mode = 1; lvbl = 1'b1;
    run_xfer(2, 15000, d_at, b_n, d_n);
    chk("vb_done_pulses", d_n, 1);
    chk("vb_busy_vs_done", b_n, d_at - 1);
    chk("vb_image_bad", image_bad_a(), 0);
    chk("vb_eng_writes", eng_k, 1024);

    // Reset during colour 100 WRHI, then a clean restart from colour 0.
    clear_mem(); rom_mode = 0; lvbl = 1'b0;
    run_xfer(4, 500, d_at, b_n, d_n);
    chk("abort_done_pulses", d_n, 0);
    chk("abort_hi100_written", wr_a[612], 1'b0);
    chk("abort_lo100_written", wr_a[100], 1'b1);
    chk("abort_lo100_data", ram_a[100], 8'd100);
    clear_mem();
    run_xfer(5, 3000, d_at, b_n, d_n);
    chk("restart_done_cycle", d_at, 2049);
    chk("restart_done_pulses", d_n, 1);
    chk("restart_image_bad", image_bad_a(), 0);

    // Random CPU traffic, blanking and ROM latency.
    clear_mem(); rom_mode = 2;
    run_xfer(3, 30000, d_at, b_n, d_n);
    chk("rnd_done_pulses", d_n, 1);
    chk("rnd_busy_vs_done", b_n, d_at - 1);
    chk("rnd_eng_writes", eng_k, 1024);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
